mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Arbitrates instruction-fetch and load/store traffic onto one
//            single-port memory, with bounded starvation of the fetch port.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    output logic        if_stall,
    output logic        d_stall
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_SERVE_I = 3'd1;
    localparam logic [2:0] c_ST_SERVE_D = 3'd2;
    localparam logic [2:0] c_ST_RESP_I  = 3'd3;
    localparam logic [2:0] c_ST_RESP_D  = 3'd4;

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [3:0]  r_starve_cnt;
    logic        r_m_we;
    logic [31:0] r_m_addr;
    logic [31:0] r_m_wdata;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;

    logic        w_in_idle;
    logic        w_starved;
    logic        w_grant_d;
    logic        w_grant_i;
    logic        w_done_i;
    logic        w_done_d;

    // Requests are only looked at in IDLE; data wins unless fetch has waited
    // through STARVE_MAX consecutive data grants.
    assign w_in_idle = (r_state == c_ST_IDLE);
    assign w_starved = (r_starve_cnt >= c_STARVE_MAX);
    assign w_grant_d = w_in_idle & d_req & (~if_req | ~w_starved);
    assign w_grant_i = w_in_idle & if_req & ~w_grant_d;
    assign w_done_i  = (r_state == c_ST_SERVE_I) & m_ready;
    assign w_done_d  = (r_state == c_ST_SERVE_D) & m_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt = c_ST_SERVE_D;
                end else if (w_grant_i) begin
                    w_state_nxt = c_ST_SERVE_I;
                end
            end
            c_ST_SERVE_I: begin
                if (m_ready) begin
                    w_state_nxt = c_ST_RESP_I;
                end
            end
            c_ST_SERVE_D: begin
                if (m_ready) begin
                    w_state_nxt = c_ST_RESP_D;
                end
            end
            c_ST_RESP_I: w_state_nxt = c_ST_IDLE;
            c_ST_RESP_D: w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        m_req  = 1'b0;
        if_ack = 1'b0;
        d_ack  = 1'b0;
        case (r_state)
            c_ST_SERVE_I: m_req  = 1'b1;
            c_ST_SERVE_D: m_req  = 1'b1;
            c_ST_RESP_I:  if_ack = 1'b1;
            c_ST_RESP_D:  d_ack  = 1'b1;
            default: begin
                m_req  = 1'b0;
                if_ack = 1'b0;
                d_ack  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Memory command latch: captured on the grant edge, held until the next
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_we    <= 1'b0;
            r_m_addr  <= 32'd0;
            r_m_wdata <= 32'd0;
        end else if (w_grant_d) begin
            r_m_we    <= d_we;
            r_m_addr  <= d_addr;
            r_m_wdata <= d_wdata;
        end else if (w_grant_i) begin
            r_m_we    <= 1'b0;
            r_m_addr  <= if_addr;
        end
    end

    // ------------------------------------------------------------------
    // Fetch starvation counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else if (w_grant_d && if_req) begin
            if (!w_starved) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end else if (w_grant_i) begin
            r_starve_cnt <= 4'd0;
        end
    end

    // ------------------------------------------------------------------
    // Read-data capture; stores leave d_rdata untouched
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_rdata <= 32'd0;
            r_d_rdata  <= 32'd0;
        end else begin
            if (w_done_i) begin
                r_if_rdata <= m_rdata;
            end
            if (w_done_d && !r_m_we) begin
                r_d_rdata <= m_rdata;
            end
        end
    end

    assign m_we     = r_m_we;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
    assign if_rdata = r_if_rdata;
    assign d_rdata  = r_d_rdata;

    assign if_stall = if_req & ~if_ack;
    assign d_stall  = d_req & ~d_ack;

endmodule
`default_nettype wire
